// File: rtl/pool_mem_write_gen_if.sv
// Write-side bundle of the pooling output address generator.
// The generator (master) consumes start/in_valid from the pooling datapath and
// drives the lane addresses, enables and status toward the next layer's buffer.
interface pool_mem_write_gen_if #(
  parameter int NUM_LANES = 2,
  parameter int ADDR_W    = 8,
  parameter int CHAN_W    = 1
);
  logic                        start;
  logic                        in_valid;
  logic [NUM_LANES*ADDR_W-1:0] wr_addr;
  logic [NUM_LANES-1:0]        wr_en;
  logic [CHAN_W-1:0]           chan;
  logic                        busy;
  logic                        done;

  modport master (
    input  start, in_valid,
    output wr_addr, wr_en, chan, busy, done
  );

  modport slave (
    output start, in_valid,
    input  wr_addr, wr_en, chan, busy, done
  );
endinterface

// File: rtl/pool_mem_write_gen.sv
// Write-address generator for pooling-layer output memories.
// One run walks NUM_CH feature maps of WORDS words, NUM_LANES words per
// in_valid beat, either splitting each map into contiguous lane segments
// (MODE 0) or interleaving lanes word by word (MODE 1).

// Per-lane address: pure function of the shared idx/chan counters.
module pool_mem_write_lane #(
  parameter int LANE      = 0,
  parameter int SEG       = 72,
  parameter int NUM_LANES = 2,
  parameter int CH_STRIDE = 144,
  parameter int MODE      = 0,
  parameter int ADDR_W    = 8,
  parameter int IDX_W     = 7,
  parameter int CHAN_W    = 1
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic [CHAN_W-1:0] chan,
  output logic [ADDR_W-1:0] addr
);
  logic [31:0] base;
  logic [31:0] off;

  // Feature-map base plus lane offset; the elaboration check in the top
  // guarantees the sum fits ADDR_W, so the final truncation loses nothing.
  always_comb begin
    base = 32'(chan) * 32'(CH_STRIDE);
    if (MODE == 0) off = 32'(LANE * SEG) + 32'(idx);
    else           off = 32'(idx) * 32'(NUM_LANES) + 32'(LANE);
    addr = ADDR_W'(base + off);
  end
endmodule

module pool_mem_write_gen #(
  parameter int WORDS     = 144,
  parameter int NUM_LANES = 2,
  parameter int NUM_CH    = 1,
  parameter int CH_STRIDE = 144,
  parameter int ADDR_W    = 8,
  parameter int PRIME_CYC = 1,
  parameter int MODE      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  pool_mem_write_gen_if.master wr
);
  localparam int SEG    = WORDS / NUM_LANES;
  localparam int IDX_W  = (SEG > 1) ? $clog2(SEG) : 1;
  localparam int CHAN_W = $clog2(NUM_CH) + 1;
  localparam int PC_W   = (PRIME_CYC > 1) ? $clog2(PRIME_CYC) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SEG - 1);
  localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(NUM_CH - 1);
  localparam logic [PC_W-1:0]   PC_LAST   = PC_W'((PRIME_CYC > 0) ? PRIME_CYC - 1 : 0);

  // Reject configurations that would alias lanes or wrap the address space.
  generate
    if (WORDS % NUM_LANES != 0) begin : g_bad_words
      $error("pool_mem_write_gen: WORDS must be divisible by NUM_LANES");
    end
    if (CH_STRIDE < WORDS) begin : g_bad_stride
      $error("pool_mem_write_gen: CH_STRIDE must be >= WORDS");
    end
    if (longint'(NUM_CH) * longint'(CH_STRIDE) > (longint'(1) << ADDR_W)) begin : g_bad_addr
      $error("pool_mem_write_gen: ADDR_W cannot hold NUM_CH*CH_STRIDE-1");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("pool_mem_write_gen: MODE must be 0 or 1");
    end
    if (PRIME_CYC < 0) begin : g_bad_prime
      $error("pool_mem_write_gen: PRIME_CYC must be >= 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [CHAN_W-1:0] chan, chan_n;
  logic [PC_W-1:0]   prime_cnt, prime_n;
  logic              beat;

  // State and counters; reset drops everything back to an idle, address-0 view.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      chan      <= '0;
      prime_cnt <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      chan      <= chan_n;
      prime_cnt <= prime_n;
    end
  end

  // Next state and counter updates; the final beat freezes idx/chan so the
  // address outputs keep showing the last location written.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    chan_n  = chan;
    prime_n = prime_cnt;
    beat    = (state == S_RUN) && wr.in_valid;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (wr.start) begin
          idx_n   = '0;
          chan_n  = '0;
          prime_n = '0;
          state_n = (PRIME_CYC == 0) ? S_RUN : S_PRIME;
        end
      end
      S_PRIME: begin
        if (prime_cnt == PC_LAST) state_n = S_RUN;
        else                      prime_n = prime_cnt + 1'b1;
      end
      S_RUN: begin
        if (wr.in_valid) begin
          if (idx == IDX_LAST) begin
            if (chan == CHAN_LAST) begin
              state_n = S_DONE;
            end else begin
              idx_n  = '0;
              chan_n = chan + 1'b1;
            end
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Lane address array; lane k lands in wr_addr[k*ADDR_W +: ADDR_W].
  logic [NUM_LANES-1:0][ADDR_W-1:0] lane_addr;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    pool_mem_write_lane #(
      .LANE      (k),
      .SEG       (SEG),
      .NUM_LANES (NUM_LANES),
      .CH_STRIDE (CH_STRIDE),
      .MODE      (MODE),
      .ADDR_W    (ADDR_W),
      .IDX_W     (IDX_W),
      .CHAN_W    (CHAN_W)
    ) u_lane (
      .idx  (idx),
      .chan (chan),
      .addr (lane_addr[k])
    );
  end

  // Write enable is combinational from in_valid so a beat writes in its own cycle.
  assign wr.wr_addr = lane_addr;
  assign wr.wr_en   = {NUM_LANES{beat}};
  assign wr.chan    = chan;
  assign wr.busy    = (state == S_PRIME) || (state == S_RUN);
  assign wr.done    = (state == S_DONE);
endmodule

// File: tb/tb_pool_mem_write_gen.sv
// Bench for pool_mem_write_gen: three configurations side by side
// (A defaults, B interleaved 4-lane, C three channels with no prime cycle).
module tb_pool_mem_write_gen;
  localparam int NI = 3;
  localparam int P_WORDS [NI] = '{144, 16, 144};
  localparam int P_NL    [NI] = '{2, 4, 2};
  localparam int P_CH    [NI] = '{1, 1, 3};
  localparam int P_STR   [NI] = '{144, 144, 150};
  localparam int P_PRIME [NI] = '{1, 1, 0};
  localparam int P_MODE  [NI] = '{0, 1, 0};

  // Hand-computed expectations that pin the model.
  localparam int FIRST_LIT [NI] = '{2, 2, 1};
  localparam int TOT_LIT   [NI] = '{72, 4, 216};
  localparam int COV_LIT   [NI] = '{144, 16, 432};
  localparam int T3_LIT [4][4] = '{'{0, 1, 2, 3}, '{4, 5, 6, 7}, '{8, 9, 10, 11}, '{12, 13, 14, 15}};
  localparam int C_L0 [3] = '{0, 150, 300};
  localparam int C_L1 [3] = '{72, 222, 372};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NI-1:0] st_v = '0;
  logic [NI-1:0] vld_v = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pool_mem_write_gen_if #(.NUM_LANES(2), .ADDR_W(8), .CHAN_W(1)) ia ();
  pool_mem_write_gen_if #(.NUM_LANES(4), .ADDR_W(8), .CHAN_W(1)) ib ();
  pool_mem_write_gen_if #(.NUM_LANES(2), .ADDR_W(9), .CHAN_W(3)) ic ();

  assign ia.start = st_v[0];
  assign ia.in_valid = vld_v[0];
  assign ib.start = st_v[1];
  assign ib.in_valid = vld_v[1];
  assign ic.start = st_v[2];
  assign ic.in_valid = vld_v[2];

  pool_mem_write_gen dut_a (.clk(clk), .reset(reset), .wr(ia));
  pool_mem_write_gen #(.WORDS(16), .NUM_LANES(4), .MODE(1)) dut_b (.clk(clk), .reset(reset), .wr(ib));
  pool_mem_write_gen #(.NUM_CH(3), .CH_STRIDE(150), .ADDR_W(9), .PRIME_CYC(0))
    dut_c (.clk(clk), .reset(reset), .wr(ic));

  // DUT outputs gathered into width-independent arrays.
  int d_addr [NI][4];
  int d_en   [NI];
  int d_chan [NI];
  int d_busy [NI];
  int d_done [NI];

  always_comb begin
    for (int j = 0; j < NI; j++) for (int k = 0; k < 4; k++) d_addr[j][k] = 0;
    for (int k = 0; k < 2; k++) d_addr[0][k] = int'(ia.wr_addr[k*8 +: 8]);
    for (int k = 0; k < 4; k++) d_addr[1][k] = int'(ib.wr_addr[k*8 +: 8]);
    for (int k = 0; k < 2; k++) d_addr[2][k] = int'(ic.wr_addr[k*9 +: 9]);
    d_en[0] = int'(ia.wr_en);   d_en[1] = int'(ib.wr_en);   d_en[2] = int'(ic.wr_en);
    d_chan[0] = int'(ia.chan);  d_chan[1] = int'(ib.chan);  d_chan[2] = int'(ic.chan);
    d_busy[0] = int'(ia.busy);  d_busy[1] = int'(ib.busy);  d_busy[2] = int'(ic.busy);
    d_done[0] = int'(ia.done);  d_done[1] = int'(ib.done);  d_done[2] = int'(ic.done);
  end

  function automatic int seg_of(input int j);
    return P_WORDS[j] / P_NL[j];
  endfunction

  function automatic int total_of(input int j);
    return P_CH[j] * seg_of(j);
  endfunction

  // Address of lane k on beat n of a run, straight from the mapping rules.
  function automatic int exp_addr(input int j, input int n, input int k);
    int c, i;
    c = n / seg_of(j);
    i = n % seg_of(j);
    if (P_MODE[j] == 0) return c * P_STR[j] + k * seg_of(j) + i;
    else                return c * P_STR[j] + i * P_NL[j] + k;
  endfunction

  // Model: phase (0 idle, 1 priming, 2 running, 3 done), beats completed, prime cycles spent.
  int m_ph [NI] = '{default: 0};
  int m_n  [NI] = '{default: 0};
  int m_pc [NI] = '{default: 0};

  initial forever begin
    @(posedge clk or posedge reset);
    for (int j = 0; j < NI; j++) begin
      if (reset) begin
        m_ph[j] = 0; m_n[j] = 0; m_pc[j] = 0;
      end else begin
        case (m_ph[j])
          0, 3: if (st_v[j]) begin
            m_n[j] = 0; m_pc[j] = 0;
            m_ph[j] = (P_PRIME[j] == 0) ? 2 : 1;
          end
          1: begin
            m_pc[j]++;
            if (m_pc[j] == P_PRIME[j]) m_ph[j] = 2;
          end
          2: if (vld_v[j]) begin
            if (m_n[j] + 1 == total_of(j)) m_ph[j] = 3;
            else m_n[j]++;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input int j, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, j, act, exp, $time);
    end
  endtask

  int prev_ph [NI] = '{default: 0};
  int cyc     [NI] = '{default: 0};
  int wb      [NI] = '{default: 0};
  int wcnt    [NI][512];
  int cn, ca, cov;

  // Compare process: every cycle, all instances, on the falling edge.
  initial forever begin
    @(negedge clk);
    for (int j = 0; j < NI; j++) begin
      if ((prev_ph[j] == 0 || prev_ph[j] == 3) && (m_ph[j] == 1 || m_ph[j] == 2)) begin
        for (int a = 0; a < 512; a++) wcnt[j][a] = 0;
        wb[j] = 0;
        cyc[j] = 1;
      end else begin
        cyc[j]++;
      end
      cn = m_n[j];
      chk("busy", j, d_busy[j], int'(m_ph[j] == 1 || m_ph[j] == 2));
      chk("done", j, d_done[j], int'(m_ph[j] == 3));
      chk("chan", j, d_chan[j], cn / seg_of(j));
      chk("wr_en", j, d_en[j], (m_ph[j] == 2 && vld_v[j]) ? (1 << P_NL[j]) - 1 : 0);
      for (int k = 0; k < P_NL[j]; k++) chk("addr", j, d_addr[j][k], exp_addr(j, cn, k));
      if (reset && j == 0) begin
        chk("rst_lane0", j, d_addr[0][0], 0);
        chk("rst_lane1", j, d_addr[0][1], 72);
        chk("rst_busy", j, d_busy[0], 0);
      end
      if (m_ph[j] == 2 && vld_v[j]) begin
        wb[j]++;
        for (int k = 0; k < P_NL[j]; k++) begin
          ca = d_addr[j][k] & 511;
          chk("no_rewrite", j, wcnt[j][ca], 0);
          wcnt[j][ca]++;
        end
        if (cn == 0) chk("first_write_cycle", j, cyc[j], FIRST_LIT[j]);
        if (j == 0 && cn == 0) begin
          chk("t1_first_l0", j, d_addr[0][0], 0);
          chk("t1_first_l1", j, d_addr[0][1], 72);
        end
        if (j == 0 && cn == 71) begin
          chk("t1_last_l0", j, d_addr[0][0], 71);
          chk("t1_last_l1", j, d_addr[0][1], 143);
        end
        if (j == 1 && cn < 4)
          for (int k = 0; k < 4; k++) chk("t3_beat", j, d_addr[1][k], T3_LIT[cn][k]);
        if (j == 2 && cn % 72 == 0 && cn / 72 < 3) begin
          chk("t4_base_l0", j, d_addr[2][0], C_L0[cn / 72]);
          chk("t4_base_l1", j, d_addr[2][1], C_L1[cn / 72]);
        end
      end
      if (prev_ph[j] == 2 && m_ph[j] == 3) begin
        chk("done_after_last", j, d_done[j], 1);
        chk("beat_count", j, wb[j], TOT_LIT[j]);
        cov = 0;
        for (int n = 0; n < total_of(j); n++)
          for (int k = 0; k < P_NL[j]; k++)
            if (wcnt[j][exp_addr(j, n, k) & 511] == 1) cov++;
        chk("coverage", j, cov, COV_LIT[j]);
      end
      prev_ph[j] = m_ph[j];
    end
  end

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; st_v = '0; vld_v = '0;
    repeat (2) cyc_step();
    reset = 1'b0;
    repeat (2) cyc_step();

    // T1: start, then 72 back-to-back beats; in_valid stays high in DONE.
    st_v[0] = 1'b1; vld_v[0] = 1'b1;
    cyc_step();
    st_v[0] = 1'b0;
    repeat (73) cyc_step();
    repeat (5) cyc_step();
    vld_v[0] = 1'b0;
    cyc_step();

    // T2: restart from DONE with in_valid toggling.
    for (int i = 0; i < 150; i++) begin
      st_v[0] = (i == 0); vld_v[0] = (i % 2 == 0);
      cyc_step();
    end
    vld_v[0] = 1'b0; st_v[0] = 1'b0;
    cyc_step();

    // T5: reset after beat 30, then a fresh run with stray starts in PRIME and RUN (T6).
    for (int i = 0; i < 32; i++) begin
      st_v[0] = (i == 0); vld_v[0] = 1'b1;
      cyc_step();
    end
    st_v[0] = 1'b0; vld_v[0] = 1'b0; reset = 1'b1;
    cyc_step();
    reset = 1'b0;
    cyc_step();
    for (int i = 0; i < 76; i++) begin
      st_v[0] = (i == 0 || i == 1 || i == 10); vld_v[0] = 1'b1;
      cyc_step();
    end
    // T6: start from DONE repeats the sequence.
    for (int i = 0; i < 76; i++) begin
      st_v[0] = (i == 0); vld_v[0] = 1'b1;
      cyc_step();
    end
    st_v[0] = 1'b0; vld_v[0] = 1'b0;
    repeat (2) cyc_step();

    // T3: interleaved 4-lane map.
    for (int i = 0; i < 8; i++) begin
      st_v[1] = (i == 0); vld_v[1] = 1'b1;
      cyc_step();
    end
    st_v[1] = 1'b0; vld_v[1] = 1'b0;
    cyc_step();

    // T4: three channels, no prime, periodic stalls.
    for (int i = 0; i < 280; i++) begin
      st_v[2] = (i == 0); vld_v[2] = (i % 5 != 3);
      cyc_step();
    end
    st_v[2] = 1'b0; vld_v[2] = 1'b0;
    repeat (3) cyc_step();

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
